// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU run sequencer.
//   - cmd_op command codes
//   - sequencer state encoding
//   - evt_flags bit positions and a helper that packs the CHECK conditions
package cpu_seq_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_CLK     = 3'd1;
  localparam logic [2:0] OP_ICLK    = 3'd2;
  localparam logic [2:0] OP_TICK    = 3'd3;
  localparam logic [2:0] OP_RUN     = 3'd4;
  localparam logic [2:0] OP_CPU_RST = 3'd5;

  localparam int FLAG_BRK   = 0;
  localparam int FLAG_HALT  = 1;
  localparam int FLAG_LIMIT = 2;
  localparam int FLAG_ABORT = 3;

  // SCLK_HI / SICLK_HI are the stand-alone single-strobe phases; CLK_HI..ICLK_LO
  // form a full tick, shared by the TICK command and by RUN.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SCLK_HI  = 4'd1,
    ST_SICLK_HI = 4'd2,
    ST_RST_HI   = 4'd3,
    ST_CLK_HI   = 4'd4,
    ST_CLK_LO   = 4'd5,
    ST_FMT_WAIT = 4'd6,
    ST_ICLK_HI  = 4'd7,
    ST_ICLK_LO  = 4'd8,
    ST_CHECK    = 4'd9,
    ST_EVT      = 4'd10
  } state_e;

  // Packs the run-termination conditions into the evt_flags layout.
  function automatic logic [3:0] pack_flags(input logic brk, input logic hlt_n,
                                            input logic limit, input logic abort);
    logic [3:0] f;
    f             = 4'b0000;
    f[FLAG_BRK]   = brk;
    f[FLAG_HALT]  = ~hlt_n;
    f[FLAG_LIMIT] = limit;
    f[FLAG_ABORT] = abort;
    return f;
  endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// Phase timer for the run sequencer.
// Reloads to PHASE_LEN-1 when 'load' is high (state change) and counts down;
// 'phase_done' is high in the last clock of a phase.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-low
//   load       in   phase entry (reload counter)
//   phase_done out  current phase has lasted PHASE_LEN clocks
module seq_phase_timer #(
  parameter int unsigned PHASE_LEN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic phase_done
);

  localparam int unsigned CW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PHASE_LEN - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload on phase entry, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_done = (cnt_q == '0);

endmodule

// File: rtl/cpu_run_sequencer.sv
// CPU clock / run sequencer.
// Executes single-shot commands (clk pulse, iclk pulse, tick, cpu reset) and RUN,
// which owns the core (ctrlen=0) and free-runs ticks until brk, halt, cycle limit
// or abort. Formatted-output words are handed off with a valid/ready stall.
// Ports:
//   clk, rst                         system clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_op       command interface (accepted only in IDLE)
//   abort                            level, ends RUN at the next CHECK
//   cpu_clk/cpu_iclk/cpu_rst/ctrlen  core strobes and control-word select
//   brk, hlt_n                       core breakpoint / halt (active-low)
//   fmt_pending/fmt_valid/fmt_ready  formatted-output handshake
//   out_rst                          clears the core formatted-out register
//   evt_valid/evt_flags/evt_ready    run-termination event {abort,limit,halt,brk}
//   busy, cycle_count                status
// All outputs are registered, decoded from the next state.
module cpu_run_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned PHASE_LEN  = 1,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             abort,
  output logic             cpu_clk,
  output logic             cpu_iclk,
  output logic             cpu_rst,
  output logic             ctrlen,
  input  logic             brk,
  input  logic             hlt_n,
  input  logic             fmt_pending,
  output logic             fmt_valid,
  input  logic             fmt_ready,
  output logic             out_rst,
  output logic             evt_valid,
  output logic [3:0]       evt_flags,
  input  logic             evt_ready,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count
);

  state_e           state_q, state_d;
  logic             run_q, run_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cpu_clk_q, cpu_clk_d;
  logic             cpu_iclk_q, cpu_iclk_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             ctrlen_q, ctrlen_d;
  logic             fmt_valid_q, fmt_valid_d;
  logic             out_rst_q, out_rst_d;
  logic             evt_valid_q, evt_valid_d;
  logic             busy_q, busy_d;
  logic             phase_done_s;
  logic             limit_s;
  logic [3:0]       check_flags_s;

  seq_phase_timer #(.PHASE_LEN(PHASE_LEN)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (state_d != state_q),
    .phase_done (phase_done_s)
  );

  assign limit_s       = (MAX_CYCLES != 32'd0) && (count_q == CNT_W'(MAX_CYCLES));
  assign check_flags_s = pack_flags(brk, hlt_n, limit_s, abort);

  // Next-state logic, run bookkeeping and registered-output decode.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    flags_d = flags_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLK:     state_d = ST_SCLK_HI;
            OP_ICLK:    state_d = ST_SICLK_HI;
            OP_TICK:    state_d = ST_CLK_HI;
            OP_CPU_RST: state_d = ST_RST_HI;
            OP_RUN: begin
              state_d = ST_CHECK;
              run_d   = 1'b1;
              flags_d = 4'b0000;
              count_d = '0;
            end
            default:    state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCLK_HI, ST_SICLK_HI, ST_RST_HI: begin
        if (phase_done_s) state_d = ST_IDLE;
        else              state_d = state_q;
      end
      ST_CLK_HI: begin
        if (phase_done_s) state_d = ST_CLK_LO;
        else              state_d = ST_CLK_HI;
      end
      ST_CLK_LO: begin
        // The formatted-output stall only exists inside RUN.
        if (phase_done_s) state_d = (run_q && fmt_pending) ? ST_FMT_WAIT : ST_ICLK_HI;
        else              state_d = ST_CLK_LO;
      end
      ST_FMT_WAIT: begin
        if (fmt_ready) state_d = ST_ICLK_HI;
        else           state_d = ST_FMT_WAIT;
      end
      ST_ICLK_HI: begin
        if (phase_done_s) state_d = ST_ICLK_LO;
        else              state_d = ST_ICLK_HI;
      end
      ST_ICLK_LO: begin
        if (phase_done_s && run_q) begin
          state_d = ST_CHECK;
          // Saturating tick counter.
          count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
        end else if (phase_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ICLK_LO;
        end
      end
      ST_CHECK: begin
        if (|check_flags_s) begin
          state_d = ST_EVT;
          flags_d = check_flags_s;
        end else begin
          state_d = ST_CLK_HI;
        end
      end
      ST_EVT: begin
        if (evt_ready) begin
          state_d = ST_IDLE;
          run_d   = 1'b0;
        end else begin
          state_d = ST_EVT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    cpu_clk_d   = (state_d == ST_SCLK_HI) || (state_d == ST_CLK_HI);
    cpu_iclk_d  = (state_d == ST_SICLK_HI) || (state_d == ST_ICLK_HI);
    cpu_rst_d   = (state_d == ST_RST_HI);
    fmt_valid_d = (state_d == ST_FMT_WAIT);
    evt_valid_d = (state_d == ST_EVT);
    ctrlen_d    = ~(run_d && (state_d != ST_EVT));
    // out_rst covers the whole ICLK_HI that follows a formatted-output handoff.
    out_rst_d   = (state_d == ST_ICLK_HI) &&
                  ((state_q == ST_FMT_WAIT) || ((state_q == ST_ICLK_HI) && out_rst_q));
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      flags_q     <= 4'b0000;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cpu_clk_q   <= 1'b0;
      cpu_iclk_q  <= 1'b0;
      cpu_rst_q   <= 1'b0;
      ctrlen_q    <= 1'b1;
      fmt_valid_q <= 1'b0;
      out_rst_q   <= 1'b0;
      evt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      flags_q     <= flags_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      cpu_clk_q   <= cpu_clk_d;
      cpu_iclk_q  <= cpu_iclk_d;
      cpu_rst_q   <= cpu_rst_d;
      ctrlen_q    <= ctrlen_d;
      fmt_valid_q <= fmt_valid_d;
      out_rst_q   <= out_rst_d;
      evt_valid_q <= evt_valid_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign cpu_clk     = cpu_clk_q;
  assign cpu_iclk    = cpu_iclk_q;
  assign cpu_rst     = cpu_rst_q;
  assign ctrlen      = ctrlen_q;
  assign fmt_valid   = fmt_valid_q;
  assign out_rst     = out_rst_q;
  assign evt_valid   = evt_valid_q;
  assign evt_flags   = flags_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer.
// dut: PHASE_LEN=2, MAX_CYCLES=10. dut_u: PHASE_LEN=1, unlimited (long abort run).
// Run-termination expectations are queued when the terminating stimulus is driven
// and popped when the DUT raises evt_valid.
module tb_cpu_run_sequencer;
  import cpu_seq_pkg::*;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic cmd_valid, cmd_ready, abort, cpu_clk, cpu_iclk, cpu_rst, ctrlen;
  logic brk, hlt_n, fmt_pending, fmt_valid, fmt_ready, out_rst;
  logic evt_valid, evt_ready, busy;
  logic [2:0] cmd_op;
  logic [3:0] evt_flags;
  logic [CNT_W-1:0] cycle_count;

  logic u_cmd_valid, u_cmd_ready, u_abort, u_cpu_clk, u_cpu_iclk, u_cpu_rst, u_ctrlen;
  logic u_fmt_valid, u_out_rst, u_evt_valid, u_evt_ready, u_busy;
  logic [2:0] u_cmd_op;
  logic [3:0] u_evt_flags;
  logic [CNT_W-1:0] u_cycle_count;

  cpu_run_sequencer #(.PHASE_LEN(2), .CNT_W(CNT_W), .MAX_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .abort(abort), .cpu_clk(cpu_clk), .cpu_iclk(cpu_iclk), .cpu_rst(cpu_rst),
    .ctrlen(ctrlen), .brk(brk), .hlt_n(hlt_n), .fmt_pending(fmt_pending),
    .fmt_valid(fmt_valid), .fmt_ready(fmt_ready), .out_rst(out_rst),
    .evt_valid(evt_valid), .evt_flags(evt_flags), .evt_ready(evt_ready),
    .busy(busy), .cycle_count(cycle_count)
  );

  cpu_run_sequencer #(.PHASE_LEN(1), .CNT_W(CNT_W), .MAX_CYCLES(0)) dut_u (
    .clk(clk), .rst(rst), .cmd_valid(u_cmd_valid), .cmd_ready(u_cmd_ready), .cmd_op(u_cmd_op),
    .abort(u_abort), .cpu_clk(u_cpu_clk), .cpu_iclk(u_cpu_iclk), .cpu_rst(u_cpu_rst),
    .ctrlen(u_ctrlen), .brk(1'b0), .hlt_n(1'b1), .fmt_pending(1'b0),
    .fmt_valid(u_fmt_valid), .fmt_ready(1'b0), .out_rst(u_out_rst),
    .evt_valid(u_evt_valid), .evt_flags(u_evt_flags), .evt_ready(u_evt_ready),
    .busy(u_busy), .cycle_count(u_cycle_count)
  );

  typedef struct {
    logic [3:0]  flags;
    int unsigned count;
    int unsigned clks;
    int unsigned iclks;
  } exp_t;

  exp_t sb_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int clk_seen = 0, iclk_seen = 0, u_iclk_seen = 0;
  int clk_base = 0, iclk_base = 0;
  logic clk_prev = 1'b0, iclk_prev = 1'b0, u_iclk_prev = 1'b0;

  // Strobe monitor: count rising edges of the strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (cpu_clk && !clk_prev)       clk_seen    <= clk_seen + 1;
    if (cpu_iclk && !iclk_prev)     iclk_seen   <= iclk_seen + 1;
    if (u_cpu_iclk && !u_iclk_prev) u_iclk_seen <= u_iclk_seen + 1;
    clk_prev    <= cpu_clk;
    iclk_prev   <= cpu_iclk;
    u_iclk_prev <= u_cpu_iclk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op);
    cmd_op    = op;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic start_run();
    clk_base  = clk_seen;
    iclk_base = iclk_seen;
    issue(OP_RUN);
    check_val("run_ctrlen_low", {busy, ctrlen}, 2'b10);
  endtask

  // Wait for evt_valid, pop the scoreboard, compare, then consume the event.
  task automatic wait_evt(input string tag);
    exp_t e;
    int cyc = 0;
    while (!evt_valid && cyc < 2000) begin
      step();
      cyc++;
    end
    check_val({tag, "_evt_seen"}, evt_valid, 1);
    check_val({tag, "_sb_entry"}, (sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val({tag, "_flags"}, evt_flags, e.flags);
      check_val({tag, "_count"}, cycle_count, e.count);
      check_val({tag, "_clks"}, clk_seen - clk_base, e.clks);
      check_val({tag, "_iclks"}, iclk_seen - iclk_base, e.iclks);
      check_val({tag, "_ctrlen"}, ctrlen, 1);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      check_val({tag, "_after_ack"}, {evt_valid, cmd_ready, busy}, 3'b010);
      check_val({tag, "_flags_kept"}, evt_flags, e.flags);
    end
  endtask

  // Stall guard.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ops [3];
    logic [2:0] bitv [3];
    logic [8:0] pat, p_clk, p_iclk, p_rdy;
    logic [6:0] p_fv, p_ic, p_or;
    logic any_evt;
    int cyc;
    int ubase;

    ops  = '{OP_CLK, OP_ICLK, OP_CPU_RST};
    bitv = '{3'b100, 3'b010, 3'b001};
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_op = OP_NOP; abort = 1'b0; brk = 1'b0; hlt_n = 1'b1;
    fmt_pending = 1'b0; fmt_ready = 1'b0; evt_ready = 1'b0;
    u_cmd_valid = 1'b0; u_cmd_op = OP_NOP; u_abort = 1'b0; u_evt_ready = 1'b0;
    repeat (3) step();

    // Reset values.
    check_val("reset_outs", {cpu_clk, cpu_iclk, cpu_rst, ctrlen, fmt_valid, out_rst, evt_valid, busy},
              8'b0001_0000);
    check_val("reset_flags", evt_flags, 0);
    check_val("reset_count", cycle_count, 0);
    rst = 1'b1;
    step();
    check_val("ready_after_reset", cmd_ready, 1);

    // Reserved opcode behaves as NOP.
    issue(3'd6);
    check_val("reserved_nop", {busy, cmd_ready}, 2'b01);

    // Single strobes: two clocks high, then IDLE.
    for (int i = 0; i < 3; i++) begin
      issue(ops[i]);
      pat = '0;
      for (int k = 0; k < 3; k++) begin
        pat = {pat[5:0], cpu_clk, cpu_iclk, cpu_rst};
        if (k < 2) step();
      end
      check_val("single_strobe", pat, {bitv[i], bitv[i], 3'b000});
      check_val("single_ready", {cmd_ready, ctrlen}, 2'b11);
    end

    // TICK with PHASE_LEN=2.
    issue(OP_TICK);
    p_clk = '0; p_iclk = '0; p_rdy = '0;
    for (int k = 0; k < 9; k++) begin
      p_clk[k]  = cpu_clk;
      p_iclk[k] = cpu_iclk;
      p_rdy[k]  = cmd_ready;
      if (k < 8) step();
    end
    check_val("tick_clk", p_clk, 9'h003);
    check_val("tick_iclk", p_iclk, 9'h030);
    check_val("tick_ready", p_rdy, 9'h100);

    // RUN, halt after 5 ticks.
    start_run();
    cyc = 0;
    while ((iclk_seen - iclk_base) < 5 && cyc < 1000) begin step(); cyc++; end
    hlt_n = 1'b0;
    sb_q.push_back('{4'b0010, 5, 5, 5});
    wait_evt("halt5");
    hlt_n = 1'b1;

    // RUN already halted and at a breakpoint: no ticks.
    brk = 1'b1; hlt_n = 1'b0;
    start_run();
    sb_q.push_back('{4'b0011, 0, 0, 0});
    wait_evt("brk_halt");
    brk = 1'b0; hlt_n = 1'b1;

    // RUN with a formatted-output word on tick 3, ready delayed.
    start_run();
    cyc = 0;
    while ((clk_seen - clk_base) < 3 && cyc < 1000) begin step(); cyc++; end
    fmt_pending = 1'b1;
    cyc = 0;
    while (!fmt_valid && cyc < 100) begin step(); cyc++; end
    p_fv = '0; p_ic = '0; p_or = '0;
    for (int k = 0; k < 7; k++) begin
      p_fv[k] = fmt_valid;
      p_ic[k] = cpu_iclk;
      p_or[k] = out_rst;
      if (k == 3) fmt_ready = 1'b1;
      if (k == 4) begin fmt_ready = 1'b0; fmt_pending = 1'b0; end
      if (k < 6) step();
    end
    check_val("fmt_valid_hold", p_fv, 7'h0F);
    check_val("fmt_iclk_after", p_ic, 7'h30);
    check_val("fmt_out_rst", p_or, 7'h30);
    abort = 1'b1;
    sb_q.push_back('{4'b1000, 3, 3, 3});
    wait_evt("fmt_abort");
    abort = 1'b0;

    // Cycle limit (MAX_CYCLES=10), core never halts.
    start_run();
    sb_q.push_back('{4'b0100, 10, 10, 10});
    wait_evt("limit");

    // Unlimited instance: abort raised at tick 20.
    ubase = u_iclk_seen;
    u_cmd_op = OP_RUN; u_cmd_valid = 1'b1;
    step();
    u_cmd_valid = 1'b0; u_cmd_op = OP_NOP;
    cyc = 0;
    while ((u_iclk_seen - ubase) < 20 && cyc < 2000) begin step(); cyc++; end
    u_abort = 1'b1;
    cyc = 0;
    while (!u_evt_valid && cyc < 100) begin step(); cyc++; end
    check_val("u_evt_seen", u_evt_valid, 1);
    check_val("u_flags", u_evt_flags, 4'b1000);
    check_val("u_count", u_cycle_count, 20);
    check_val("u_ctrlen", u_ctrlen, 1);
    u_abort = 1'b0;
    u_evt_ready = 1'b1;
    step();
    u_evt_ready = 1'b0;
    check_val("u_ready", u_cmd_ready, 1);
    check_val("u_idle", {u_busy, u_fmt_valid, u_out_rst, u_cpu_clk, u_cpu_rst, u_evt_valid}, 6'b0);

    // Asynchronous reset while stalled in FMT_WAIT.
    fmt_pending = 1'b1;
    start_run();
    cyc = 0;
    while (!fmt_valid && cyc < 200) begin step(); cyc++; end
    check_val("rst_fmt_wait", fmt_valid, 1);
    #1;
    rst = 1'b0;
    #1;
    check_val("rst_async_outs", {cpu_clk, cpu_iclk, cpu_rst, ctrlen, fmt_valid, out_rst, evt_valid, busy},
              8'b0001_0000);
    check_val("rst_async_count", cycle_count, 0);
    fmt_pending = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_val("rst_release_ready", cmd_ready, 1);
    any_evt = 1'b0;
    for (int k = 0; k < 20; k++) begin
      any_evt = any_evt | evt_valid | busy;
      step();
    end
    check_val("rst_no_event", any_evt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
